// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array tile scheduler.
// Holds the scheduler FSM encoding and the accumulation-counter width helper.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Width able to hold 0..kmax inclusive.
  function automatic int sa_wkc(input int kmax);
    return $clog2(kmax + 1);
  endfunction

endpackage

// File: rtl/axis_sa_sched_if.sv
// Bundle of job, X/K stream, SA input and SA output-monitor signals around axis_sa_sched.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface axis_sa_sched_if #(
  parameter int R    = 4,
  parameter int C    = 4,
  parameter int WX   = 8,
  parameter int WK   = 8,
  parameter int KMAX = 64,
  parameter int WT   = 16
);
  import sa_pkg::*;
  localparam int WKC = sa_wkc(KMAX);

  logic              cfg_valid, cfg_ready;
  logic [WKC-1:0]    cfg_k;
  logic [WT-1:0]     cfg_tiles;
  logic              x_valid, x_ready;
  logic [R*WX-1:0]   x_data;
  logic              k_valid, k_ready;
  logic [C*WK-1:0]   k_data;
  logic              s_valid, s_ready, s_last;
  logic [R*WX-1:0]   sx_data;
  logic [C*WK-1:0]   sk_data;
  logic              mon_valid, mon_ready, mon_last;
  logic              busy, done;

  modport slave (
    input  cfg_valid, cfg_k, cfg_tiles, x_valid, x_data, k_valid, k_data,
           s_ready, mon_valid, mon_ready, mon_last,
    output cfg_ready, x_ready, k_ready, s_valid, s_last, sx_data, sk_data, busy, done
  );

  modport master (
    output cfg_valid, cfg_k, cfg_tiles, x_valid, x_data, k_valid, k_data,
           s_ready, mon_valid, mon_ready, mon_last,
    input  cfg_ready, x_ready, k_ready, s_valid, s_last, sx_data, sk_data, busy, done
  );

endinterface

// File: rtl/axis_join2.sv
// Two-input valid/ready join: the output fires only when both inputs and the sink agree.
// Purely combinational; no input is consumed alone and o_vld never looks at o_rdy.
module axis_join2 (
  input  logic en,
  input  logic a_vld,
  output logic a_rdy,
  input  logic b_vld,
  output logic b_rdy,
  output logic o_vld,
  input  logic o_rdy
);

  assign o_vld = en & a_vld & b_vld;
  assign a_rdy = en & o_rdy & b_vld;
  assign b_rdy = en & o_rdy & a_vld;

endmodule

// File: rtl/axis_sa_sched.sv
// Tile scheduler in front of axis_sa: joins X/K streams, marks tile ends, bounds tiles in flight.
// Zero-latency data join; feeding stalls while MAXOUT tiles await retirement on the monitor tap.
module axis_sa_sched #(
  parameter int R      = 4,
  parameter int C      = 4,
  parameter int WX     = 8,
  parameter int WK     = 8,
  parameter int KMAX   = 64,
  parameter int MAXOUT = 2,
  parameter int WT     = 16
) (
  input  logic            clk,
  input  logic            rstn,
  axis_sa_sched_if.slave  io
);
  import sa_pkg::*;

  localparam int WKC = sa_wkc(KMAX);
  localparam int WCR = $clog2(MAXOUT + 1);

  sched_state_t    state;
  logic [WKC-1:0]  k_q, bcnt;
  logic [WT-1:0]   tiles_q, tiles_fed, tiles_done;
  logic [WCR-1:0]  credit;
  logic            cfg_ready_q, busy_q, done_q;
  logic            feed_en, beat, bcnt_end, last_beat, retire, retire_ok, active;
  logic [R*WX-1:0] x_word;
  logic [C*WK-1:0] k_word;

  assign active  = (state == FEED) || (state == DRAIN);
  assign feed_en = (state == FEED) && (credit < WCR'(MAXOUT));

  axis_join2 u_join (
    .en    (feed_en),
    .a_vld (io.x_valid),
    .a_rdy (io.x_ready),
    .b_vld (io.k_valid),
    .b_rdy (io.k_ready),
    .o_vld (io.s_valid),
    .o_rdy (io.s_ready)
  );

  assign x_word     = io.x_data;
  assign k_word     = io.k_data;
  assign io.sx_data = x_word;
  assign io.sk_data = k_word;

  assign beat      = io.s_valid & io.s_ready;
  assign bcnt_end  = (bcnt == k_q - 1'b1);
  assign last_beat = beat & bcnt_end;
  assign io.s_last = io.s_valid & bcnt_end;

  // A retire with nothing outstanding is a protocol error and is dropped.
  assign retire    = io.mon_valid & io.mon_ready & io.mon_last;
  assign retire_ok = retire && active && (credit != '0);

  assign io.cfg_ready = cfg_ready_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      k_q         <= '0;
      tiles_q     <= '0;
      bcnt        <= '0;
      tiles_fed   <= '0;
      tiles_done  <= '0;
      credit      <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.cfg_valid) begin
            k_q         <= io.cfg_k;
            tiles_q     <= io.cfg_tiles;
            bcnt        <= '0;
            tiles_fed   <= '0;
            tiles_done  <= '0;
            credit      <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            // An empty job skips straight to completion.
            if (io.cfg_k == '0 || io.cfg_tiles == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= FEED;
            end
          end
        end
        FEED, DRAIN: begin
          if (beat)      bcnt <= bcnt_end ? '0 : bcnt + 1'b1;
          if (last_beat) tiles_fed <= tiles_fed + 1'b1;
          if (retire_ok) tiles_done <= tiles_done + 1'b1;
          credit <= credit + WCR'(last_beat) - WCR'(retire_ok);
          if (state == FEED && last_beat && tiles_fed == tiles_q - 1'b1)
            state <= DRAIN;
          if (state == DRAIN && (tiles_done + WT'(retire_ok)) == tiles_q) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_retire_with_credit: assert property (@(posedge clk) disable iff (!rstn)
    !(retire && active && credit == '0));

endmodule
